// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to a 32-entry register
// file, and provides bypassed ID read ports, EX forwarding flags and a retired-write counter.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_in,
  input  logic              mem2reg_in,
  input  logic [DATA_W-1:0] mem_read_data_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [ADDR_W-1:0] dst_addr_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] ex_rs_addr,
  input  logic [ADDR_W-1:0] ex_rt_addr,
  output logic              fwd_rs,
  output logic              fwd_rt,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [31:0]       wb_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [31:0]       count_q;
  logic              wr_valid;

  assign wb_data_out = mem2reg_in ? mem_read_data_in : ALU_result_in;
  assign wr_valid    = wb_in && rst_n && (dst_addr_in != '0);
  assign wb_count    = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      count_q <= '0;
    end else if (wr_valid) begin
      regs[dst_addr_in] <= wb_data_out;
      count_q           <= count_q + 32'd1;
    end
  end

  // Address 0 reads as zero last, so it overrides a bypass hit as well.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (BYPASS != 0 && wr_valid && rs_addr == dst_addr_in) rs_data = wb_data_out;
    if (BYPASS != 0 && wr_valid && rt_addr == dst_addr_in) rt_data = wb_data_out;
    if (rs_addr == '0) rs_data = '0;
    if (rt_addr == '0) rt_data = '0;
  end

  // Forwarding flags deliberately ignore rst_n.
  assign fwd_rs = wb_in && (dst_addr_in != '0) && (dst_addr_in == ex_rs_addr);
  assign fwd_rt = wb_in && (dst_addr_in != '0) && (dst_addr_in == ex_rt_addr);

endmodule
